// File: rtl/arith_pkg.sv
// Shared arithmetic-library definitions: default operand width, serial FSM
// state encoding and the full-subtractor equations.
package arith_pkg;

    localparam int DEFAULT_WIDTH = 4;

    // 2'd3 is unused; the serial FSM recovers from it to IDLE.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic logic fs_diff(input logic a, input logic b, input logic bin);
        return a ^ b ^ bin;
    endfunction

    function automatic logic fs_borrow(input logic a, input logic b, input logic bin);
        return (~a & b) | (~(a ^ b) & bin);
    endfunction

endpackage

// File: rtl/scazator_serial_4_biti_if.sv
// Operand/result bus of the bit-serial subtractor; the controller is the
// master, the subtractor the slave.
interface scazator_serial_4_biti_if
    import arith_pkg::*;
#(
    parameter int N = DEFAULT_WIDTH
);

    logic         start;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         BIN;
    logic         ready;
    logic         done;
    logic [N-1:0] D;
    logic         bout;

    modport master (
        output start, A, B, BIN,
        input  ready, done, D, bout
    );

    modport slave (
        input  start, A, B, BIN,
        output ready, done, D, bout
    );

endinterface

// File: rtl/scazator_complet_1_bit.sv
// Combinational one-bit full subtractor: d = a - b - bin, bout is the borrow.
module scazator_complet_1_bit
    import arith_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = fs_diff(a, b, bin);
    assign bout = fs_borrow(a, b, bin);

endmodule

// File: rtl/scazator_serial_4_biti.sv
// Bit-serial ripple-borrow subtractor: D = A - B - BIN, one bit per clock,
// LSB first, through a single full-subtractor cell and a borrow flip-flop.
module scazator_serial_4_biti
    import arith_pkg::*;
#(
    parameter int N = DEFAULT_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    scazator_serial_4_biti_if.slave   bus
);

    localparam int CW = $clog2(N + 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic [N-1:0]  a_sr;
    logic [N-1:0]  b_sr;
    logic [N-1:0]  r_sr;
    logic          br;

    logic          ready_q;
    logic          done_q;
    logic [N-1:0]  d_q;
    logic          bout_q;

    logic          cell_d;
    logic          cell_bout;
    logic [N-1:0]  r_next;
    logic          last_bit;

    scazator_complet_1_bit u_cell (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (br),
        .d    (cell_d),
        .bout (cell_bout)
    );

    // New difference bits enter at the MSB so the LSB-first result lands in place.
    assign r_next   = (r_sr >> 1) | (N'(cell_d) << (N - 1));
    assign last_bit = (cnt == CW'(N - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            a_sr    <= '0;
            b_sr    <= '0;
            r_sr    <= '0;
            br      <= 1'b0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            d_q     <= '0;
            bout_q  <= 1'b0;
        end else begin
            case (state)
                // DONE accepts a new start exactly like IDLE, giving N+1 cycle throughput.
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        a_sr    <= bus.A;
                        b_sr    <= bus.B;
                        br      <= bus.BIN;
                        cnt     <= '0;
                        r_sr    <= '0;
                        state   <= SHIFT;
                        ready_q <= 1'b0;
                    end else begin
                        state   <= IDLE;
                        ready_q <= 1'b1;
                    end
                end
                SHIFT: begin
                    a_sr <= a_sr >> 1;
                    b_sr <= b_sr >> 1;
                    r_sr <= r_next;
                    br   <= cell_bout;
                    cnt  <= cnt + CW'(1);
                    if (last_bit) begin
                        state   <= DONE;
                        ready_q <= 1'b1;
                        done_q  <= 1'b1;
                        d_q     <= r_next;
                        bout_q  <= cell_bout;
                    end
                end
                default: begin
                    state   <= IDLE;
                    ready_q <= 1'b1;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ready = ready_q;
    assign bus.done  = done_q;
    assign bus.D     = d_q;
    assign bus.bout  = bout_q;

endmodule
